rx_fifo_ctrl: RTL and testbench
===============================

Name: rx_fifo_ctrl

Overview:
Packet-level controller for the USB receive FIFO. Sequences bytes from the USB RX decoder into the FIFO write port and tracks occupancy and packet boundaries. Serves single-byte reads to the host/AHB side and performs flush-drain after errors or on host command. Sits between the USB RX block, the rx FIFO instance and the host interface.

Parameters:
DEPTH, 8, FIFO depth in bytes; must match the attached FIFO instance.
CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rx_byte_valid  in  1  one-cycle strobe; rx_byte is valid
rx_byte  in  8  received data byte
rx_eop  in  1  one-cycle strobe; end of packet, no data carried
rx_error  in  1  one-cycle strobe; PID/CRC/bitstuff error in the current packet
fifo_w_enable  out  1  FIFO write strobe (combinational)
fifo_w_data  out  8  FIFO write data (combinational copy of rx_byte)
fifo_r_enable  out  1  FIFO pop strobe (combinational)
fifo_r_data  in  8  FIFO head byte; first-word-fall-through, valid while !fifo_empty
fifo_full  in  1  FIFO full
fifo_empty  in  1  FIFO empty
rd_req  in  1  host requests one byte
rd_data  out  8  registered byte returned to host
rd_valid  out  1  one-cycle strobe; rd_data valid
flush  in  1  host discards all FIFO contents
packet_ready  out  1  complete packet held, not yet fully read
rx_count  out  CNT_W  bytes currently in FIFO
overflow  out  1  sticky; a byte was dropped
data_error  out  1  sticky; rx_error seen

Behaviour:
- Reset (async, active-high): state IDLE. rx_count=0, rd_data=0, rd_valid=0, packet_ready=0, overflow=0, data_error=0. FIFO strobes are low.
- FSM states: IDLE, RECEIVE, DONE, ERROR, DRAIN.
- IDLE: rx_byte_valid -> write byte, go RECEIVE. Clear overflow on this first byte. rx_eop alone -> stay IDLE (zero-length packet ignored).
- RECEIVE:
  - rx_byte_valid with !fifo_full -> fifo_w_enable=1 in the same cycle.
  - rx_byte_valid with fifo_full -> byte dropped, overflow set.
  - rx_eop -> DONE.
  - rx_error -> ERROR with data_error set. rx_error takes priority over rx_eop in the same cycle.
- DONE:
  - packet_ready=1.
  - Incoming rx_byte_valid is dropped and sets overflow; the USB side must NAK.
  - When rx_count reaches 0 through reads -> IDLE, and packet_ready falls in the same cycle as the transition.
- ERROR: writes are blocked; reads are blocked. Wait for flush.
- flush (any state) -> DRAIN. flush has priority over all other inputs.
- DRAIN:
  - fifo_r_enable=1 every cycle while !fifo_empty; rx_count decrements each pop.
  - When fifo_empty is seen -> IDLE, with rx_count=0 and data_error and overflow cleared.
  - rx inputs are ignored in DRAIN.
- Reads (RECEIVE and DONE only):
  - rd_req with rx_count>0 -> fifo_r_enable=1 that cycle.
  - rd_data <= fifo_r_data and rd_valid=1 on the next cycle; latency is 1.
  - rd_req with rx_count==0, or in another state -> ignored, no rd_valid.
  - Back-to-back rd_req gives one byte per cycle.
- rx_count: +1 on accepted write, -1 on pop, unchanged when both occur in the same cycle. It never wraps; overflow and underflow are prevented by the full/empty gating.
- Reset mid-packet: all state is cleared. FIFO contents are undefined; the host must flush after reset.

Decomposition:
- Package rx_ctrl_pkg: state_t enum {IDLE, RECEIVE, DONE, ERROR, DRAIN}, DEPTH_DEFAULT.
- One sub-module, rx_occ_counter: up/down occupancy counter with inc/dec/clear inputs.
- FSM and read-return register live in the top level.

Test Plan:
- Reset, then 3 bytes 0xA1,0xB2,0xC3 + eop -> 3 fifo_w_enable pulses, rx_count=3, packet_ready=1, state DONE.
- From DONE, rd_req for 3 cycles -> rd_valid on cycles 2-4 with rd_data A1,B2,C3; rx_count 3->0; packet_ready low after the last pop.
- 10 bytes into DEPTH=8 with fifo_full asserted after 8 -> 8 writes, bytes 9-10 dropped, overflow=1, rx_count=8.
- 2 bytes then rx_error and rx_eop together -> ERROR, data_error=1, rd_req ignored. Then flush -> 2 pops, rx_count=0, IDLE, flags cleared.
- RECEIVE with rx_count=2, rx_byte_valid and rd_req in the same cycle -> one write and one pop, rx_count stays 2, rd_valid next cycle.
- rst asserted mid-RECEIVE, asynchronously between clock edges -> outputs zero immediately, state IDLE after release.

Source files
------------

// File: rtl/rx_fifo_ctrl_pkg.sv
// Shared types and defaults for the USB receive FIFO controller.
package rx_ctrl_pkg;

  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECEIVE = 3'd1,
    DONE    = 3'd2,
    ERROR   = 3'd3,
    DRAIN   = 3'd4
  } state_t;

endpackage

// File: rtl/rx_fifo_ctrl_if.sv
// Bundle of USB RX, FIFO-port and host-side signals around the receive controller.
interface rx_fifo_ctrl_if import rx_ctrl_pkg::*; #(
  parameter int CNT_W = $clog2(DEPTH_DEFAULT + 1)
) ();

  logic             rx_byte_valid;
  logic [7:0]       rx_byte;
  logic             rx_eop;
  logic             rx_error;
  logic             fifo_w_enable;
  logic [7:0]       fifo_w_data;
  logic             fifo_r_enable;
  logic [7:0]       fifo_r_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rd_req;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             flush;
  logic             packet_ready;
  logic [CNT_W-1:0] rx_count;
  logic             overflow;
  logic             data_error;

  modport slave (
    input  rx_byte_valid, rx_byte, rx_eop, rx_error,
    input  fifo_r_data, fifo_full, fifo_empty, rd_req, flush,
    output fifo_w_enable, fifo_w_data, fifo_r_enable,
    output rd_data, rd_valid, packet_ready, rx_count, overflow, data_error
  );

  modport master (
    output rx_byte_valid, rx_byte, rx_eop, rx_error,
    output fifo_r_data, fifo_full, fifo_empty, rd_req, flush,
    input  fifo_w_enable, fifo_w_data, fifo_r_enable,
    input  rd_data, rd_valid, packet_ready, rx_count, overflow, data_error
  );

endinterface

// File: rtl/rx_fifo_ctrl_occ_counter.sv
// Saturating up/down occupancy counter; simultaneous inc and dec leave it unchanged.
module rx_occ_counter #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: clear wins, then a lone inc or dec within [0, DEPTH]
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = CNT_ZERO;
    end else if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else if (dec_i && !inc_i && (count_q != CNT_ZERO)) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Packet-level controller for the USB receive FIFO: writes RX bytes, tracks
// occupancy and packet boundaries, returns single bytes to the host, drains on flush.
module rx_fifo_ctrl import rx_ctrl_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  rx_fifo_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             packet_ready_q, packet_ready_d;
  logic             overflow_q, overflow_d;
  logic             data_error_q, data_error_d;
  logic             w_en_s, host_rd_s, drain_pop_s, clear_s, has_data_s;
  logic [CNT_W-1:0] count_s;

  rx_occ_counter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_occ (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (w_en_s),
    .dec_i   (bus.fifo_r_enable),
    .clear_i (clear_s),
    .count_o (count_s)
  );

  assign has_data_s = (count_s != CNT_ZERO);

  // next-state, FIFO strobes and sticky flag updates
  always_comb begin
    state_d      = state_q;
    w_en_s       = 1'b0;
    host_rd_s    = 1'b0;
    drain_pop_s  = 1'b0;
    clear_s      = 1'b0;
    overflow_d   = overflow_q;
    data_error_d = data_error_q;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end else if (bus.rx_byte_valid) begin
          // first byte of a packet restarts the overflow history
          w_en_s     = ~bus.fifo_full;
          overflow_d = bus.fifo_full;
          state_d    = RECEIVE;
        end else begin
          state_d = IDLE;
        end
      end
      RECEIVE: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end else begin
          host_rd_s = bus.rd_req && has_data_s;
          if (bus.rx_byte_valid && !bus.rx_error) begin
            if (bus.fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              w_en_s = 1'b1;
            end
          end else begin
            w_en_s = 1'b0;
          end
          if (bus.rx_error) begin
            state_d      = ERROR;
            data_error_d = 1'b1;
          end else if (bus.rx_eop) begin
            state_d = DONE;
          end else begin
            state_d = RECEIVE;
          end
        end
      end
      DONE: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end else begin
          host_rd_s = bus.rd_req && has_data_s;
          if (bus.rx_byte_valid) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          if (!has_data_s || (host_rd_s && (count_s == CNT_ONE))) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ERROR: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end else begin
          state_d = ERROR;
        end
      end
      DRAIN: begin
        if (bus.fifo_empty) begin
          state_d      = IDLE;
          clear_s      = 1'b1;
          overflow_d   = 1'b0;
          data_error_d = 1'b0;
        end else begin
          drain_pop_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // read-return and packet-ready next values
  always_comb begin
    rd_valid_d     = host_rd_s;
    rd_data_d      = rd_data_q;
    packet_ready_d = (state_d == DONE);
    if (host_rd_s) begin
      rd_data_d = bus.fifo_r_data;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rd_data_q      <= 8'h00;
      rd_valid_q     <= 1'b0;
      packet_ready_q <= 1'b0;
      overflow_q     <= 1'b0;
      data_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      packet_ready_q <= packet_ready_d;
      overflow_q     <= overflow_d;
      data_error_q   <= data_error_d;
    end
  end

  assign bus.fifo_w_enable = w_en_s;
  assign bus.fifo_w_data   = bus.rx_byte;
  assign bus.fifo_r_enable = host_rd_s | drain_pop_s;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.packet_ready  = packet_ready_q;
  assign bus.rx_count      = count_s;
  assign bus.overflow      = overflow_q;
  assign bus.data_error    = data_error_q;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed, table-driven bench for rx_fifo_ctrl with a small depth-8 FWFT FIFO attached.
module tb_rx_fifo_ctrl;

  typedef struct {
    logic       bv;
    logic [7:0] rxb;
    logic       eop, err, rd, fl;
    logic       wen, ren, rdv;
    logic [7:0] rdd;
    logic [3:0] cnt;
    logic       pr, ovf, derr;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  vec_t vq[$];
  int   rst_at;

  rx_fifo_ctrl_if #(.CNT_W(4)) bus ();

  rx_fifo_ctrl #(.DEPTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // attached FIFO: depth 8, first-word-fall-through
  logic [7:0] fmem [0:7];
  logic [2:0] fwp, frp;
  logic [3:0] fcnt;
  logic       m_push, m_pop;

  assign m_push          = bus.fifo_w_enable && (fcnt != 4'd8);
  assign m_pop           = bus.fifo_r_enable && (fcnt != 4'd0);
  assign bus.fifo_full   = (fcnt == 4'd8);
  assign bus.fifo_empty  = (fcnt == 4'd0);
  assign bus.fifo_r_data = fmem[frp];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fwp  <= 3'd0;
      frp  <= 3'd0;
      fcnt <= 4'd0;
    end else begin
      if (m_push) begin
        fmem[fwp] <= bus.fifo_w_data;
        fwp       <= fwp + 3'd1;
      end
      if (m_pop) frp <= frp + 3'd1;
      fcnt <= fcnt + {3'd0, m_push} - {3'd0, m_pop};
    end
  end

  task automatic add(input logic bv, input logic [7:0] rxb, input logic eop, input logic err,
                     input logic rd, input logic fl, input logic wen, input logic ren,
                     input logic rdv, input logic [7:0] rdd, input logic [3:0] cnt,
                     input logic pr, input logic ovf, input logic derr);
    vec_t v;
    v.bv = bv; v.rxb = rxb; v.eop = eop; v.err = err; v.rd = rd; v.fl = fl;
    v.wen = wen; v.ren = ren; v.rdv = rdv; v.rdd = rdd; v.cnt = cnt;
    v.pr = pr; v.ovf = ovf; v.derr = derr;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.rx_byte_valid = 1'b0;
    bus.rx_byte       = 8'h00;
    bus.rx_eop        = 1'b0;
    bus.rx_error      = 1'b0;
    bus.rd_req        = 1'b0;
    bus.flush         = 1'b0;
  endtask

  task automatic apply(input int idx);
    vec_t       v;
    logic       wen_a, ren_a, ok;
    logic [7:0] wd_a;
    v = vq[idx];
    @(negedge clk);
    bus.rx_byte_valid = v.bv;
    bus.rx_byte       = v.rxb;
    bus.rx_eop        = v.eop;
    bus.rx_error      = v.err;
    bus.rd_req        = v.rd;
    bus.flush         = v.fl;
    #1;
    wen_a = bus.fifo_w_enable;
    ren_a = bus.fifo_r_enable;
    wd_a  = bus.fifo_w_data;
    @(posedge clk);
    #1;
    ok = (wen_a === v.wen) && (ren_a === v.ren) && (!v.wen || (wd_a === v.rxb)) &&
         (bus.rd_valid === v.rdv) && (bus.rd_data === v.rdd) && (bus.rx_count === v.cnt) &&
         (bus.packet_ready === v.pr) && (bus.overflow === v.ovf) && (bus.data_error === v.derr);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got wen=%b wdata=%h ren=%b rdv=%b rdd=%h cnt=%0d pr=%b ovf=%b derr=%b; want wen=%b wdata=%h ren=%b rdv=%b rdd=%h cnt=%0d pr=%b ovf=%b derr=%b",
               idx, wen_a, wd_a, ren_a, bus.rd_valid, bus.rd_data, bus.rx_count, bus.packet_ready,
               bus.overflow, bus.data_error, v.wen, v.rxb, v.ren, v.rdv, v.rdd, v.cnt, v.pr, v.ovf, v.derr);
    end
    idle_inputs();
  endtask

  task automatic chk_zero(input string tag);
    n_vec++;
    if ((bus.rx_count !== 4'd0) || (bus.rd_data !== 8'h00) || (bus.rd_valid !== 1'b0) ||
        (bus.packet_ready !== 1'b0) || (bus.overflow !== 1'b0) || (bus.data_error !== 1'b0) ||
        (bus.fifo_w_enable !== 1'b0) || (bus.fifo_r_enable !== 1'b0)) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d rdd=%h rdv=%b pr=%b ovf=%b derr=%b wen=%b ren=%b, want all zero",
               tag, bus.rx_count, bus.rd_data, bus.rd_valid, bus.packet_ready, bus.overflow,
               bus.data_error, bus.fifo_w_enable, bus.fifo_r_enable);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    idle_inputs();

    // 3-byte packet, then read it back
    add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 8'hA1, 4'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 8'hB2, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 8'hC3, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 8'hC3, 4'd0, 1'b0, 1'b0, 1'b0);
    // 10 bytes into a depth-8 FIFO: last two dropped
    for (int k = 0; k < 8; k++)
      add(1'b1, 8'h10 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 4'(k + 1), 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h18, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'hC3, 4'd8, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'h19, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'hC3, 4'd8, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'hC3, 4'd8, 1'b1, 1'b1, 1'b0);
    add(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'hC3, 4'd8, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10 + 8'(k), 4'(7 - k),
          (k < 7) ? 1'b1 : 1'b0, 1'b1, 1'b0);
    // new packet clears overflow; error with eop; blocked reads/writes; flush-drain
    add(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h17, 4'd1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h17, 4'd2, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h17, 4'd2, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 8'h17, 4'd2, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h17, 4'd2, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 8'h17, 4'd2, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 8'h17, 4'd1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 8'h17, 4'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h17, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h17, 4'd1, 1'b0, 1'b0, 1'b0);
    // write and pop in the same cycle
    add(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h17, 4'd2, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h32, 1'b0, 1'b0, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 8'h30, 4'd2, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 8'h31, 4'd1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h31, 4'd1, 1'b0, 1'b0, 1'b0);
    rst_at = vq.size();
    // after mid-packet reset: zero-length packet, idle read, flush priority
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 8'h40, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 8'h40, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h40, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'h40, 4'd1, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    #2;
    chk_zero("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < rst_at; i++) apply(i);

    // asynchronous reset between clock edges while in RECEIVE with data held
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_reset_mid_packet");
    @(negedge clk);
    rst = 1'b0;

    for (int i = rst_at; i < vq.size(); i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
